// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control and sequencing for the stopwatch timebase. Debounces the start,
//   clear and lap buttons, runs the IDLE/RUN/PAUSE/LAP state machine, gates
//   and clears the timebase divider, and counts 1 s ticks into an MM:SS BCD
//   time. The display word shows either the live time or a frozen lap value.
//
//   Ports
//     Clk_100mhz  in   system clock, rising edge
//     Rst_n       in   asynchronous active-low reset
//     Btn_start   in   start/stop button (async, active-high)
//     Btn_clear   in   clear button (async, active-high)
//     Btn_lap     in   lap/split button (async, active-high)
//     Tick        in   one-cycle 1 Hz enable from the timebase
//     Tb_en       out  timebase enable, high in RUN and LAP
//     Tb_clr      out  one-cycle synchronous clear to the timebase divider
//     Disp        out  BCD {min_tens,min_units,sec_tens,sec_units}
//     State       out  FSM state: IDLE=0 RUN=1 PAUSE=2 LAP=3
//     Wrap        out  one-cycle pulse on the 59:59 -> 00:00 rollover
//
//   Handshake: there is no valid/ready traffic here; every input and output
//   is a level or a single-cycle pulse sampled on the rising clock edge.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        Clk_100mhz,
  input  logic        Rst_n,
  input  logic        Btn_start,
  input  logic        Btn_clear,
  input  logic        Btn_lap,
  input  logic        Tick,
  output logic        Tb_en,
  output logic        Tb_clr,
  output logic [15:0] Disp,
  output logic [1:0]  State,
  output logic        Wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button vectors are indexed {lap, clear, start}.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       acc_q, acc_d;
  logic [2:0]       acc_dly_q, acc_dly_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_e      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [15:0] lap_q, lap_d;
  logic [15:0] disp_q, disp_d;
  logic        tb_en_q, tb_en_d;
  logic        tb_clr_q, tb_clr_d;
  logic        wrap_q, wrap_d;

  logic [2:0] press;
  logic       start_p, clear_p, lap_p;
  logic       counting;

  // Synchroniser and debounce: the counter only runs while the synchronised
  // level disagrees with the accepted level, so any bounce back restarts it.
  always_comb begin
    sync1_d   = {Btn_lap, Btn_clear, Btn_start};
    sync2_d   = sync1_q;
    acc_d     = acc_q;
    acc_dly_d = acc_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Clear beats start beats lap; a losing press is simply dropped.
  assign press   = acc_q & ~acc_dly_q;
  assign clear_p = press[1];
  assign start_p = press[0] & ~press[1];
  assign lap_p   = press[2] & ~press[1] & ~press[0];

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

  always_comb begin
    state_d  = state_q;
    lap_d    = lap_q;
    tb_clr_d = 1'b0;
    time_d   = time_q;
    wrap_d   = 1'b0;

    // BCD ripple increment; a tick on a stop press still counts because
    // this looks at the pre-transition state.
    if (counting && Tick) begin
      if (time_q[3:0] != 4'd9) begin
        time_d[3:0] = time_q[3:0] + 4'd1;
      end else begin
        time_d[3:0] = 4'd0;
        if (time_q[7:4] != 4'd5) begin
          time_d[7:4] = time_q[7:4] + 4'd1;
        end else begin
          time_d[7:4] = 4'd0;
          if (time_q[11:8] != 4'd9) begin
            time_d[11:8] = time_q[11:8] + 4'd1;
          end else begin
            time_d[11:8] = 4'd0;
            if (time_q[15:12] != 4'd5) begin
              time_d[15:12] = time_q[15:12] + 4'd1;
            end else begin
              time_d[15:12] = 4'd0;
              wrap_d        = 1'b1;
            end
          end
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_p) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d = ST_LAP;
          lap_d   = time_q;
        end
      end
      ST_LAP: begin
        if (start_p)    state_d = ST_PAUSE;
        else if (lap_p) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear_p) begin
          state_d  = ST_IDLE;
          time_d   = 16'h0000;
          tb_clr_d = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tb_en_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    disp_d  = (state_q == ST_LAP) ? lap_q : time_q;
  end

  always_ff @(posedge Clk_100mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q   <= ST_IDLE;
      time_q    <= '0;
      lap_q     <= '0;
      disp_q    <= '0;
      tb_en_q   <= 1'b0;
      tb_clr_q  <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      acc_q     <= acc_d;
      acc_dly_q <= acc_dly_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      time_q    <= time_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      tb_en_q   <= tb_en_d;
      tb_clr_q  <= tb_clr_d;
      wrap_q    <= wrap_d;
    end
  end

  assign Tb_en  = tb_en_q;
  assign Tb_clr = tb_clr_q;
  assign Disp   = disp_q;
  assign State  = state_q;
  assign Wrap   = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Directed plus randomised bench for stopwatch_ctrl. The reference model
//   keeps the time as a plain count of seconds and converts it to BCD only
//   when an expected display value is needed.
module tb_stopwatch_ctrl;

  localparam int DC = 4;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic        tick = 1'b0;
  logic        tb_en;
  logic        tb_clr;
  logic [15:0] disp;
  logic [1:0]  state;
  logic        wrap;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .Clk_100mhz(clk),
    .Rst_n     (rst_n),
    .Btn_start (btn_start),
    .Btn_clear (btn_clear),
    .Btn_lap   (btn_lap),
    .Tick      (tick),
    .Tb_en     (tb_en),
    .Tb_clr    (tb_clr),
    .Disp      (disp),
    .State     (state),
    .Wrap      (wrap)
  );

  // Reference model: state code 0..3, elapsed seconds 0..3599, lap seconds
  int tests_run = 0;
  int fail_cnt  = 0;
  int m_state   = 0;
  int m_sec     = 0;
  int m_lap     = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic m_running();
    return (m_state == 1) || (m_state == 3);
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    @(posedge clk); #1;
    chk({tag, "_state"}, 16'(state), 16'(m_state));
    chk({tag, "_tb_en"}, 16'(tb_en), 16'(m_running()));
    chk({tag, "_disp"}, disp, (m_state == 3) ? to_bcd(m_lap) : to_bcd(m_sec));
  endtask

  // Driver tasks; all are entered and left 1 time unit after a rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_state = 0; m_sec = 0; m_lap = 0;
    chk({tag, "_rst_disp"}, disp, 16'h0000);
    chk({tag, "_rst_tbclr"}, 16'(tb_clr), 16'h0);
    chk({tag, "_rst_wrap"}, 16'(wrap), 16'h0);
    rst_n = 1'b1;
    check_all({tag, "_post"});
  endtask

  task automatic press(input logic s, input logic c, input logic l, input string tag);
    int clr_seen;
    int exp_clr;
    int win;
    clr_seen = 0;
    exp_clr  = 0;
    btn_start = s; btn_clear = c; btn_lap = l;
    for (int i = 0; i < DC + 6; i++) begin
      @(posedge clk); #1;
      clr_seen += int'(tb_clr);
    end
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    for (int i = 0; i < DC + 6; i++) begin
      @(posedge clk); #1;
      clr_seen += int'(tb_clr);
    end
    if (c)      win = 1;
    else if (s) win = 0;
    else        win = 2;
    case (m_state)
      0: if (win == 0) m_state = 1;
      1: begin
        if (win == 0) m_state = 2;
        else if (win == 2) begin m_state = 3; m_lap = m_sec; end
      end
      3: begin
        if (win == 0)      m_state = 2;
        else if (win == 2) m_state = 1;
      end
      default: begin
        if (win == 1) begin m_state = 0; m_sec = 0; exp_clr = 1; end
        else if (win == 0) m_state = 1;
      end
    endcase
    chk({tag, "_tbclr_pulses"}, 16'(clr_seen), 16'(exp_clr));
    check_all(tag);
  endtask

  task automatic glitch(input string tag);
    int len;
    int which;
    len   = $urandom_range(1, DC - 1);
    which = $urandom_range(0, 2);
    btn_start = (which == 0); btn_clear = (which == 1); btn_lap = (which == 2);
    repeat (len) @(posedge clk);
    #1;
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    repeat (DC + 4) @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    logic exp_wrap;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      exp_wrap = m_running() && (m_sec == 3599);
      chk({tag, "_wrap"}, 16'(wrap), 16'(exp_wrap));
      if (m_running()) m_sec = (m_sec + 1) % 3600;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int op;
    int mask;
    #1;
    // 1. reset state
    do_reset("t1");
    chk("t1_state_idle", 16'(state), 16'h0);

    // 2. start, 75 ticks
    press(1'b1, 1'b0, 1'b0, "t2_start");
    ticks(75, "t2");
    check_all("t2_run");
    chk("t2_disp_0115", disp, 16'h0115);

    // 3. short pulse rejected
    btn_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn_start = 1'b0;
    repeat (DC + 4) @(posedge clk);
    #1;
    check_all("t3_glitch");
    chk("t3_state_run", 16'(state), 16'h1);

    // 4. lap at 00:10
    press(1'b1, 1'b0, 1'b0, "t4_pause");
    ticks(3, "t4_pause_ticks");
    check_all("t4_pause_hold");
    press(1'b0, 1'b1, 1'b0, "t4_clear");
    press(1'b1, 1'b0, 1'b0, "t4_run");
    ticks(10, "t4a");
    press(1'b0, 1'b0, 1'b1, "t4_lap");
    ticks(5, "t4b");
    check_all("t4_lap_hold");
    chk("t4_disp_0010", disp, 16'h0010);
    press(1'b0, 1'b0, 1'b1, "t4_unlap");
    chk("t4_disp_0015", disp, 16'h0015);

    // 5. full hour and rollover
    do_reset("t5");
    press(1'b1, 1'b0, 1'b0, "t5_start");
    ticks(3599, "t5");
    check_all("t5_5959");
    chk("t5_disp_5959", disp, 16'h5959);
    ticks(1, "t5_roll");
    check_all("t5_0000");
    chk("t5_disp_0000", disp, 16'h0000);

    // 6. clear and start together in PAUSE
    ticks(7, "t6");
    press(1'b1, 1'b0, 1'b0, "t6_pause");
    press(1'b1, 1'b1, 1'b0, "t6_clr_start");
    chk("t6_idle", 16'(state), 16'h0);

    // 7. async reset mid-run at 00:42
    press(1'b1, 1'b0, 1'b0, "t7_start");
    ticks(42, "t7");
    check_all("t7_0042");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_async_state", 16'(state), 16'h0);
    chk("t7_async_disp", disp, 16'h0000);
    chk("t7_async_tb_en", 16'(tb_en), 16'h0);
    chk("t7_async_tb_clr", 16'(tb_clr), 16'h0);
    chk("t7_async_wrap", 16'(wrap), 16'h0);
    @(posedge clk); #1;
    do_reset("t7_rel");

    // Randomised operations against the model
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 5);
      if (op <= 3) begin
        mask = $urandom_range(1, 7);
        press(mask[0], mask[1], mask[2], "rnd_press");
      end else if (op == 4) begin
        glitch("rnd_glitch");
      end else begin
        ticks($urandom_range(1, 80), "rnd_ticks");
        check_all("rnd_after_ticks");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
